// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the ALU control sequencer.
// Holds op codes, control classes, instruction opcodes, state codes.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] CTL_ADD = 2'b00;
  localparam logic [1:0] CTL_SUB = 2'b01;
  localparam logic [1:0] CTL_OPC = 2'b10;
  localparam logic [1:0] CTL_SLT = 2'b11;

  localparam logic [3:0] OPC_ADD = 4'd1;
  localparam logic [3:0] OPC_SUB = 4'd2;
  localparam logic [3:0] OPC_AND = 4'd3;
  localparam logic [3:0] OPC_OR  = 4'd4;
  localparam logic [3:0] OPC_SLL = 4'd5;
  localparam logic [3:0] OPC_SRL = 4'd6;
  localparam logic [3:0] OPC_MUL = 4'd7;
  localparam logic [3:0] OPC_SLT = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef struct packed {
    logic [2:0] op;
    logic       illegal;
    logic       iter;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: request/response bundle of the ALU sequencer.
// master drives Start/ALUControl/Opcode/A/B; slave returns results.
interface alu_ctrl_seq_if #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4
);
  logic              Start;
  logic [1:0]        ALUControl;
  logic [OPC_W-1:0]  Opcode;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [2:0]        ALUOpCode;
  logic [DATA_W-1:0] Result;
  logic              Zero;
  logic              Busy;
  logic              Done;
  logic              Illegal;

  modport master (
    output Start, ALUControl, Opcode, A, B,
    input  ALUOpCode, Result, Zero,
    input  Busy, Done, Illegal
  );

  modport slave (
    input  Start, ALUControl, Opcode, A, B,
    output ALUOpCode, Result, Zero,
    output Busy, Done, Illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: ctrl class + opcode -> op, illegal, iterative.
// Ports: ctrl, opcode in; dec out. Macro ALU_CTRL_SEQ_MUL_EN adds MUL.
import alu_ctrl_pkg::*;

module alu_ctrl_decode #(
  parameter int OPC_W = 4
) (
  input  logic [1:0]       ctrl,
  input  logic [OPC_W-1:0] opcode,
  output dec_t             dec
);

  always_comb begin
    dec.op      = OP_ADD;
    dec.illegal = 1'b0;
    dec.iter    = 1'b0;
    unique case (ctrl)
      CTL_ADD: dec.op = OP_ADD;
      CTL_SUB: dec.op = OP_SUB;
      CTL_SLT: dec.op = OP_SLT;
      default: begin
        unique case (1'b1)
          opcode == OPC_W'(OPC_ADD):
            dec.op = OP_ADD;
          opcode == OPC_W'(OPC_SUB):
            dec.op = OP_SUB;
          opcode == OPC_W'(OPC_AND):
            dec.op = OP_AND;
          opcode == OPC_W'(OPC_OR):
            dec.op = OP_OR;
          opcode == OPC_W'(OPC_SLL): begin
            dec.op   = OP_SLL;
            dec.iter = 1'b1;
          end
          opcode == OPC_W'(OPC_SRL): begin
            dec.op   = OP_SRL;
            dec.iter = 1'b1;
          end
`ifdef ALU_CTRL_SEQ_MUL_EN
          opcode == OPC_W'(OPC_MUL): begin
            dec.op   = OP_MUL;
            dec.iter = 1'b1;
          end
`endif
          opcode == OPC_W'(OPC_SLT):
            dec.op = OP_SLT;
          default:
            dec.illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: IDLE/RUN/DONE sequencer with iterative shift/MUL ALU.
// Ports: CLK, Reset (async, high), bus (slave). Macro ALU_CTRL_SEQ_MUL_EN.
import alu_ctrl_pkg::*;

module alu_ctrl_seq #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4
) (
  input logic           CLK,
  input logic           Reset,
  alu_ctrl_seq_if.slave bus
);

  localparam int SHW = $clog2(DATA_W);
  localparam int CW  = SHW + 1;

  dec_t dec;

  alu_ctrl_decode #(.OPC_W(OPC_W)) u_dec (
    .ctrl   (bus.ALUControl),
    .opcode (bus.Opcode),
    .dec    (dec)
  );

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] w;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic [2:0]        op_r;
  logic              ill_r;

  logic              accept;
  logic [CW-1:0]     n_acc;
  logic [DATA_W-1:0] quick;
  logic [DATA_W-1:0] step;
  logic              lt;

  // Start is only heard outside RUN; DONE may accept directly.
  assign accept = bus.Start && (state != ST_RUN);
  assign lt     = $signed(bus.A) < $signed(bus.B);

  always_comb begin
    n_acc = '0;
    if (dec.iter) begin
      if (dec.op == OP_SLL || dec.op == OP_SRL)
        n_acc = CW'(bus.B[SHW-1:0]);
      else
        n_acc = CW'(DATA_W);
    end
  end

  // Shifts by zero land here too and simply pass A through.
  always_comb begin
    quick = bus.A;
    unique case (dec.op)
      OP_ADD:  quick = bus.A + bus.B;
      OP_SUB:  quick = bus.A - bus.B;
      OP_AND:  quick = bus.A & bus.B;
      OP_OR:   quick = bus.A | bus.B;
      OP_SLT:  quick = {{(DATA_W-1){1'b0}}, lt};
      default: quick = bus.A;
    endcase
  end

`ifdef ALU_CTRL_SEQ_MUL_EN
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mp;

  // For MUL, w is the multiplicand shifted up each step.
  always_comb begin
    step = acc + (mp[0] ? w : '0);
    unique case (op_r)
      OP_SLL:  step = w << 1;
      OP_SRL:  step = w >> 1;
      default: step = acc + (mp[0] ? w : '0);
    endcase
  end
`else
  always_comb begin
    step = (op_r == OP_SLL) ? (w << 1) : (w >> 1);
  end
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      w      <= '0;
      result <= '0;
      zero   <= 1'b1;
      op_r   <= OP_ADD;
      ill_r  <= 1'b0;
`ifdef ALU_CTRL_SEQ_MUL_EN
      acc    <= '0;
      mp     <= '0;
`endif
    end else if (accept) begin
      op_r  <= dec.op;
      ill_r <= dec.illegal;
      w     <= bus.A;
`ifdef ALU_CTRL_SEQ_MUL_EN
      acc   <= '0;
      mp    <= bus.B;
`endif
      if (dec.iter && n_acc != '0) begin
        state <= ST_RUN;
        cnt   <= n_acc;
      end else begin
        state  <= ST_DONE;
        cnt    <= '0;
        result <= quick;
        zero   <= (quick == '0);
      end
    end else if (state == ST_RUN) begin
`ifdef ALU_CTRL_SEQ_MUL_EN
      if (op_r == OP_MUL) begin
        acc <= step;
        w   <= w << 1;
        mp  <= mp >> 1;
      end else begin
        w <= step;
      end
`else
      w <= step;
`endif
      cnt <= cnt - 1'b1;
      // Port result only moves on the final step.
      if (cnt == CW'(1)) begin
        state  <= ST_DONE;
        result <= step;
        zero   <= (step == '0);
      end
    end else if (state == ST_DONE) begin
      state <= ST_IDLE;
    end
  end

  assign bus.Result    = result;
  assign bus.Zero      = zero;
  assign bus.ALUOpCode = op_r;
  assign bus.Illegal   = ill_r;
  assign bus.Busy      = (state == ST_RUN);
  assign bus.Done      = (state == ST_DONE);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: table vectors, random model checks, corner sequences.
// Drives alu_ctrl_seq (DATA_W=16) through alu_ctrl_seq_if.
module tb_alu_ctrl_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_ctrl_seq_if #(.DATA_W(16), .OPC_W(4)) bus ();

  alu_ctrl_seq #(.DATA_W(16), .OPC_W(4)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  c;
    logic [3:0]  o;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [2:0]  op;
    logic        ill;
    int          n;
    bit          poke;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: opcodes 1..8 map in order onto op codes 0..7.
  function automatic void model(input logic [1:0] c,
                                input logic [3:0] o,
                                input logic [15:0] a,
                                input logic [15:0] b,
                                output logic [15:0] r,
                                output logic [2:0] op,
                                output logic ill,
                                output int n);
    logic [31:0] p;
    int sh;
    ill = 1'b0;
    op  = 3'd0;
    if (c == 2'b01) op = 3'd1;
    else if (c == 2'b11) op = 3'd7;
    else if (c == 2'b10) begin
      if (o >= 4'd1 && o <= 4'd8) op = 3'(o - 4'd1);
      else ill = 1'b1;
`ifndef ALU_CTRL_SEQ_MUL_EN
      if (o == 4'd7) begin
        op  = 3'd0;
        ill = 1'b1;
      end
`endif
    end
    sh = int'(b[3:0]);
    p  = a * b;
    n  = 0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin r = a << sh; n = sh; end
      3'd5: begin r = a >> sh; n = sh; end
      3'd6: begin r = p[15:0]; n = 16; end
      default: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
    endcase
  endfunction

  task automatic do_req(input string nm, input vec_t v);
    int edges;
    int busy;
    bit stable;
    logic [15:0] held;
    @(negedge clk);
    bus.ALUControl = v.c;
    bus.Opcode     = v.o;
    bus.A          = v.a;
    bus.B          = v.b;
    bus.Start      = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    edges  = 1;
    busy   = 0;
    stable = 1'b1;
    held   = bus.Result;
    chk({nm, " op"}, 64'(bus.ALUOpCode), 64'(v.op));
    chk({nm, " ill"}, 64'(bus.Illegal), 64'(v.ill));
    chk({nm, " busy1"}, 64'(bus.Busy), 64'(v.n > 0));
    while (!bus.Done && edges < 60) begin
      if (bus.Busy) busy++;
      if (bus.Result !== held) stable = 1'b0;
      if (v.poke) begin
        bus.Start = 1'($urandom_range(0, 1));
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
      end
      @(posedge clk);
      #1;
      edges++;
    end
    bus.Start = 1'b0;
    chk({nm, " done_edge"}, 64'(edges), 64'(v.n + 1));
    chk({nm, " busy_cycles"}, 64'(busy), 64'(v.n));
    chk({nm, " held"}, 64'(stable), 64'd1);
    chk({nm, " result"}, 64'(bus.Result), 64'(v.r));
    chk({nm, " zero"}, 64'(bus.Zero), 64'(v.r == 16'd0));
    chk({nm, " op_end"}, 64'(bus.ALUOpCode), 64'(v.op));
    @(posedge clk);
    #1;
    chk({nm, " idle"}, 64'({bus.Done, bus.Busy}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   dcnt;
    total = 0;
    bad   = 0;

    vt.push_back('{2'b00, 4'h0, 16'h0005, 16'h0007,
                   16'h000C, 3'd0, 1'b0, 0, 1'b0});
    vt.push_back('{2'b01, 4'h0, 16'h0003, 16'h0003,
                   16'h0000, 3'd1, 1'b0, 0, 1'b0});
    vt.push_back('{2'b11, 4'h0, 16'hFFFF, 16'h0001,
                   16'h0001, 3'd7, 1'b0, 0, 1'b0});
    vt.push_back('{2'b10, 4'h5, 16'h0001, 16'h0004,
                   16'h0010, 3'd4, 1'b0, 4, 1'b1});
`ifdef ALU_CTRL_SEQ_MUL_EN
    vt.push_back('{2'b10, 4'h7, 16'h0012, 16'h0003,
                   16'h0036, 3'd6, 1'b0, 16, 1'b1});
`else
    vt.push_back('{2'b10, 4'h7, 16'h0012, 16'h0003,
                   16'h0015, 3'd0, 1'b1, 0, 1'b0});
`endif
    vt.push_back('{2'b10, 4'hF, 16'h0003, 16'h0004,
                   16'h0007, 3'd0, 1'b1, 0, 1'b0});
    vt.push_back('{2'b10, 4'h6, 16'h8000, 16'h000F,
                   16'h0001, 3'd5, 1'b0, 15, 1'b0});
    vt.push_back('{2'b10, 4'h3, 16'hF0F0, 16'h3C3C,
                   16'h3030, 3'd2, 1'b0, 0, 1'b0});
    vt.push_back('{2'b10, 4'h4, 16'h00F0, 16'h0F00,
                   16'h0FF0, 3'd3, 1'b0, 0, 1'b0});
    vt.push_back('{2'b10, 4'h5, 16'hABCD, 16'h0010,
                   16'hABCD, 3'd4, 1'b0, 0, 1'b0});
    vt.push_back('{2'b10, 4'h0, 16'h0001, 16'h0001,
                   16'h0002, 3'd0, 1'b1, 0, 1'b0});
    vt.push_back('{2'b00, 4'h0, 16'hFFFF, 16'h0001,
                   16'h0000, 3'd0, 1'b0, 0, 1'b0});
    vt.push_back('{2'b11, 4'h0, 16'h0001, 16'hFFFF,
                   16'h0000, 3'd7, 1'b0, 0, 1'b0});
    vt.push_back('{2'b10, 4'h8, 16'h8000, 16'h7FFF,
                   16'h0001, 3'd7, 1'b0, 0, 1'b0});

    rst            = 1'b1;
    bus.Start      = 1'b0;
    bus.ALUControl = 2'b00;
    bus.Opcode     = 4'h0;
    bus.A          = 16'h0;
    bus.B          = 16'h0;
    #3;
    chk("rst result", 64'(bus.Result), 64'd0);
    chk("rst zero", 64'(bus.Zero), 64'd1);
    chk("rst op", 64'(bus.ALUOpCode), 64'd0);
    chk("rst flags",
        64'({bus.Busy, bus.Done, bus.Illegal}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) do_req($sformatf("vec%0d", i), vt[i]);

    for (int i = 0; i < 40; i++) begin
      v.c    = 2'($urandom_range(0, 3));
      v.o    = 4'($urandom_range(0, 15));
      v.a    = 16'($urandom);
      v.b    = 16'($urandom);
      v.poke = 1'($urandom_range(0, 1));
      model(v.c, v.o, v.a, v.b, v.r, v.op, v.ill, v.n);
      do_req($sformatf("rnd%0d", i), v);
    end

    // Back-to-back: ADD, SUB accepted in DONE, then SLL from DONE.
    @(negedge clk);
    bus.ALUControl = 2'b00;
    bus.A          = 16'd1;
    bus.B          = 16'd2;
    bus.Start      = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b done1", 64'(bus.Done), 64'd1);
    chk("b2b res1", 64'(bus.Result), 64'd3);
    bus.ALUControl = 2'b01;
    bus.A          = 16'd9;
    bus.B          = 16'd4;
    @(posedge clk);
    #1;
    chk("b2b done2", 64'(bus.Done), 64'd1);
    chk("b2b res2", 64'(bus.Result), 64'd5);
    chk("b2b op2", 64'(bus.ALUOpCode), 64'd1);
    bus.ALUControl = 2'b10;
    bus.Opcode     = 4'h5;
    bus.A          = 16'd1;
    bus.B          = 16'd2;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    chk("b2b run", 64'({bus.Busy, bus.Done}), 64'b10);
    chk("b2b op3", 64'(bus.ALUOpCode), 64'd4);
    @(posedge clk);
    #1;
    chk("b2b run2", 64'({bus.Busy, bus.Done}), 64'b10);
    @(posedge clk);
    #1;
    chk("b2b done3", 64'(bus.Done), 64'd1);
    chk("b2b res3", 64'(bus.Result), 64'd4);
    @(posedge clk);
    #1;

    // Abort a long request with reset after its 8th edge.
    @(negedge clk);
    bus.ALUControl = 2'b10;
`ifdef ALU_CTRL_SEQ_MUL_EN
    bus.Opcode = 4'h7;
`else
    bus.Opcode = 4'h5;
`endif
    bus.A     = 16'h0012;
    bus.B     = 16'h000F;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
    end
    chk("abort busy_pre", 64'(bus.Busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort busy", 64'(bus.Busy), 64'd0);
    chk("abort result", 64'(bus.Result), 64'd0);
    chk("abort zero", 64'(bus.Zero), 64'd1);
    chk("abort op", 64'(bus.ALUOpCode), 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      if (bus.Done) dcnt++;
    end
    chk("abort no_done", 64'(dcnt), 64'd0);

    // First edge after reset release accepts.
    rst = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    bus.ALUControl = 2'b00;
    bus.A          = 16'd2;
    bus.B          = 16'd2;
    bus.Start      = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    chk("post_rst done", 64'(bus.Done), 64'd1);
    chk("post_rst res", 64'(bus.Result), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width; power of two, 8..64.
REQ-002 Parameter OPC_W, default 4, instruction opcode width; minimum 4.
REQ-003 Local constant SHW = $clog2(DATA_W), shift-amount width.
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Start  input  1  request; sampled only in IDLE or DONE.
REQ-007 ALUControl  input  2  main-control class: 00 ADD, 01 SUB, 11 SLT, 10 decode Opcode.
REQ-008 Opcode  input  OPC_W  instruction opcode, used when ALUControl=10.
REQ-009 A, B  input  DATA_W each  operands, captured on accepting edge.
REQ-010 ALUOpCode  output  3  registered operation of current/last request.
REQ-011 Result  output  DATA_W  registered result, held until next accept.
REQ-012 Zero  output  1  registered (Result==0).
REQ-013 Busy  output  1  high while in RUN.
REQ-014 Done  output  1  one-cycle completion pulse.
REQ-015 Illegal  output  1  registered; request's opcode unsupported.

Function
REQ-016 ALUOpCode encodings SHALL be 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRL, 110 MUL, 111 SLT.
REQ-017 ALUControl=10 SHALL decode Opcode 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 SLL, 0110 SRL, 0111 MUL, 1000 SLT; all other values ADD with Illegal=1.
REQ-018 States SHALL be IDLE, RUN, DONE; Start in IDLE or DONE accepts; Start in RUN is ignored without effect.
REQ-019 Accepting edge (edge 1) SHALL capture A, B, decoded op, Illegal, and iteration count N.
REQ-020 ADD, SUB, AND, OR, SLT (signed) and shifts with N=0 SHALL complete on edge 1: Result written, state DONE.
REQ-021 SLL/SRL SHALL use N = B[SHW-1:0], shift one bit per cycle in RUN; SRL logical.
REQ-022 MUL SHALL use N = DATA_W shift-add steps; Result = low DATA_W bits of A*B (unsigned).
REQ-023 With N>0: state RUN after edge 1, one step per edge on edges 2..N+1, DONE after edge N+1.
REQ-024 Done SHALL be high exactly during the single cycle the state is DONE; DONE returns to IDLE next edge unless Start accepted.
REQ-025 Start in DONE SHALL begin the next request with no idle bubble; Done still pulses once for the finished request.
REQ-026 ADD/SUB SHALL wrap modulo 2^DATA_W; no overflow output.
REQ-027 Result, Zero, ALUOpCode, Illegal SHALL change only on an accepting edge or completion edge; Result is not updated mid-RUN at the port.

Reset
REQ-028 Reset SHALL force IDLE, Result=0, Zero=1, ALUOpCode=000, Busy=0, Done=0, Illegal=0, counter=0, immediately and independent of CLK.
REQ-029 Reset during RUN SHALL abort; no Done pulse for the aborted request.
REQ-030 First accept SHALL be possible on first rising edge after Reset deasserts.

Configuration
REQ-031 Macro ALU_CTRL_SEQ_MUL_EN defined: MUL per REQ-022.
REQ-032 Macro undefined: Opcode 0111 treated as illegal (ADD, Illegal=1, single cycle); no multiplier iteration logic synthesised.

Structure
REQ-033 Package alu_ctrl_pkg SHALL hold the ALUOpCode encodings, ALUControl class constants, opcode constants and the state encoding.
REQ-034 Combinational decode (ALUControl, Opcode -> op, Illegal, iterative flag) SHALL be sub-module alu_ctrl_decode; sequencer and datapath remain in alu_ctrl_seq.

Verification (DATA_W=16)
REQ-035 Reset; ALUControl=00, A=5, B=7, Start -> Done after edge 1, Result=0x000C, ALUOpCode=000, Busy never high.
REQ-036 ALUControl=01, A=B=3 -> Result=0, Zero=1, ALUOpCode=001; ALUControl=11, A=0xFFFF, B=1 -> Result=1.
REQ-037 ALUControl=10, Opcode=0101, A=0x0001, B=4 -> Busy 4 cycles, Done after edge 5, Result=0x0010; Start pulses during RUN ignored.
REQ-038 Opcode=0111, A=0x0012, B=0x0003 -> macro defined: Done after edge 17, Result=0x0036; undefined: Done after edge 1, Result=0x0015, Illegal=1.
REQ-039 Opcode=1111 -> ALUOpCode=000, Illegal=1; back-to-back Start in DONE -> two Done pulses, no IDLE gap.
REQ-040 Reset asserted at edge 8 of MUL -> Busy=0, Result=0 immediately, no Done pulse.
